// File: rtl/mem_stage_pkg.sv
// Shared types, FUNCT3 encodings and lane helpers for the memory-stage controller.
package mem_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FUNCT3 size/sign encodings; bits [1:0] give the size, bit 2 marks unsigned loads
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] ofs);
        logic [BE_W-1:0] be;
        case (f3)
            F3_B:    be = BE_W'(4'b0001) << ofs;
            F3_H:    be = BE_W'(4'b0011) << {ofs[1], 1'b0};
            default: be = BE_W'(4'b1111);
        endcase
        return be;
    endfunction

    // Narrow stores are replicated so every enabled lane carries the payload
    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (f3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic misaligned_access(input logic [2:0] f3, input logic [1:0] ofs);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = ofs[0];
            default: mis = |ofs;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module load_extender
    import mem_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c      = 8'(rdata >> {lane, 3'b000});
        half_c      = 16'(rdata >> {lane[1], 4'b0000});
        load_data_c = rdata;
        case (funct3)
            F3_B:    load_data_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   load_data_c = {24'h0, byte_c};
            F3_H:    load_data_c = {{16{half_c[15]}}, half_c};
            F3_HU:   load_data_c = {16'h0, half_c};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: IDLE/REQ/DONE handshake with ack timeout.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                MEM_READ,
    input  logic                MEM_WRITE,
    input  logic [2:0]          FUNCT3,
    input  logic [XLEN-1:0]     ALU_OUTPUT,
    input  logic [XLEN-1:0]     DATA2,
    output logic                BUSYWAIT,
    output logic [XLEN-1:0]     LOAD_DATA,
    output logic                LOAD_VALID,
    output logic                BUS_ERROR,
    output logic                MISALIGNED,
    output logic                DMEM_READ,
    output logic                DMEM_WRITE,
    output logic [XLEN-1:0]     DMEM_ADDR,
    output logic [XLEN-1:0]     DMEM_WDATA,
    output logic [BE_W-1:0]     DMEM_BYTE_EN,
    input  logic [XLEN-1:0]     DMEM_RDATA,
    input  logic                DMEM_ACK
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic              rd_d, wr_d, lvalid_d, berr_d;
    logic [XLEN-1:0]   addr_d, wdata_d, ldata_d;
    logic [BE_W-1:0]   be_d;
    logic              req_c, issue_ok_c;
    logic [XLEN-1:0]   ext_data_c;

    assign req_c = MEM_READ | MEM_WRITE;

    // Stall while a request waits in IDLE or is outstanding; reset forces it low
    assign BUSYWAIT = ~RESET & (((state_q == IDLE) & req_c) | (state_q == REQ));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic mis_d;
    assign issue_ok_c = ~misaligned_access(FUNCT3, ALU_OUTPUT[1:0]);
`else
    assign issue_ok_c = 1'b1;
    assign MISALIGNED = 1'b0;
`endif

    load_extender u_load_extender (
        .funct3      (f3_q),
        .lane        (lane_q),
        .rdata       (DMEM_RDATA),
        .load_data_c (ext_data_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        lane_d   = lane_q;
        rd_d     = DMEM_READ;
        wr_d     = DMEM_WRITE;
        addr_d   = DMEM_ADDR;
        wdata_d  = DMEM_WDATA;
        be_d     = DMEM_BYTE_EN;
        ldata_d  = LOAD_DATA;
        lvalid_d = 1'b0;
        berr_d   = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        mis_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    if (issue_ok_c) begin
                        state_d = REQ;
                        cnt_d   = '0;
                        f3_d    = FUNCT3;
                        lane_d  = ALU_OUTPUT[1:0];
                        addr_d  = {ALU_OUTPUT[XLEN-1:2], 2'b00};
                        wdata_d = store_data(FUNCT3, DATA2);
                        be_d    = byte_en(FUNCT3, ALU_OUTPUT[1:0]);
                        wr_d    = MEM_WRITE;
                        rd_d    = ~MEM_WRITE;
                    end else begin
                        state_d = DONE;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end
                end
            end
            REQ: begin
                if (DMEM_ACK) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (DMEM_READ) begin
                        ldata_d  = ext_data_c;
                        lvalid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            lane_q       <= '0;
            DMEM_READ    <= 1'b0;
            DMEM_WRITE   <= 1'b0;
            DMEM_ADDR    <= '0;
            DMEM_WDATA   <= '0;
            DMEM_BYTE_EN <= '0;
            LOAD_DATA    <= '0;
            LOAD_VALID   <= 1'b0;
            BUS_ERROR    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            DMEM_READ    <= rd_d;
            DMEM_WRITE   <= wr_d;
            DMEM_ADDR    <= addr_d;
            DMEM_WDATA   <= wdata_d;
            DMEM_BYTE_EN <= be_d;
            LOAD_DATA    <= ldata_d;
            LOAD_VALID   <= lvalid_d;
            BUS_ERROR    <= berr_d;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) MISALIGNED <= 1'b0;
        else       MISALIGNED <= mis_d;
    end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (ACK_TIMEOUT = 4).
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ, MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ALU_OUTPUT, DATA2, DMEM_RDATA;
    logic        DMEM_ACK;
    logic        BUSYWAIT, LOAD_VALID, BUS_ERROR, MISALIGNED, DMEM_READ, DMEM_WRITE;
    logic [31:0] LOAD_DATA, DMEM_ADDR, DMEM_WDATA;
    logic [3:0]  DMEM_BYTE_EN;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(.ACK_TIMEOUT(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .FUNCT3       (FUNCT3),
        .ALU_OUTPUT   (ALU_OUTPUT),
        .DATA2        (DATA2),
        .BUSYWAIT     (BUSYWAIT),
        .LOAD_DATA    (LOAD_DATA),
        .LOAD_VALID   (LOAD_VALID),
        .BUS_ERROR    (BUS_ERROR),
        .MISALIGNED   (MISALIGNED),
        .DMEM_READ    (DMEM_READ),
        .DMEM_WRITE   (DMEM_WRITE),
        .DMEM_ADDR    (DMEM_ADDR),
        .DMEM_WDATA   (DMEM_WDATA),
        .DMEM_BYTE_EN (DMEM_BYTE_EN),
        .DMEM_RDATA   (DMEM_RDATA),
        .DMEM_ACK     (DMEM_ACK)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] d2);
        MEM_READ   = rd;
        MEM_WRITE  = wr;
        FUNCT3     = f3;
        ALU_OUTPUT = addr;
        DATA2      = d2;
        #1;
    endtask

    task automatic quiet;
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        DMEM_ACK  = 1'b0;
    endtask

    int pulses;

    initial begin
        RESET = 1'b1;
        quiet();
        FUNCT3 = 3'b000; ALU_OUTPUT = '0; DATA2 = '0; DMEM_RDATA = '0;
        #2;
        chk("rst_dmem_read", 32'(DMEM_READ), 32'd0);
        chk("rst_dmem_addr", DMEM_ADDR, 32'h0);
        chk("rst_load_data", LOAD_DATA, 32'h0);
        chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
        tick(); tick();
        RESET = 1'b0;

        // LW 0x100, ack on first REQ cycle
        DMEM_RDATA = 32'hDEADBEEF;
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_idle_busy", 32'(BUSYWAIT), 32'd1);
        chk("lw_idle_nostrobe", 32'(DMEM_READ), 32'd0);
        tick();
        chk("lw_req_busy", 32'(BUSYWAIT), 32'd1);
        chk("lw_req_strobe", 32'(DMEM_READ), 32'd1);
        chk("lw_req_addr", DMEM_ADDR, 32'h100);
        chk("lw_req_be", 32'(DMEM_BYTE_EN), 32'hF);
        DMEM_ACK = 1'b1;
        tick();
        DMEM_ACK = 1'b0;
        chk("lw_done_busy", 32'(BUSYWAIT), 32'd0);
        chk("lw_done_strobe", 32'(DMEM_READ), 32'd0);
        chk("lw_done_valid", 32'(LOAD_VALID), 32'd1);
        chk("lw_done_data", LOAD_DATA, 32'hDEADBEEF);
        quiet();
        tick();
        chk("lw_valid_pulse", 32'(LOAD_VALID), 32'd0);

        // LB 0x103 then LBU 0x103
        DMEM_RDATA = 32'h80FFFF00;
        drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        tick();
        chk("lb_addr", DMEM_ADDR, 32'h100);
        chk("lb_be", 32'(DMEM_BYTE_EN), 32'h8);
        DMEM_ACK = 1'b1;
        tick();
        chk("lb_data", LOAD_DATA, 32'hFFFFFF80);
        quiet(); tick();
        drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
        tick();
        DMEM_ACK = 1'b1;
        tick();
        chk("lbu_data", LOAD_DATA, 32'h00000080);
        chk("lbu_valid", 32'(LOAD_VALID), 32'd1);
        quiet(); tick();

        // LH 0x102 (upper halfword, negative)
        DMEM_RDATA = 32'h80017FFF;
        drive(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
        tick();
        chk("lh_be", 32'(DMEM_BYTE_EN), 32'hC);
        DMEM_ACK = 1'b1;
        tick();
        chk("lh_data", LOAD_DATA, 32'hFFFF8001);
        quiet(); tick();

        // SH 0x202
        drive(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD);
        tick();
        chk("sh_write", 32'(DMEM_WRITE), 32'd1);
        chk("sh_addr", DMEM_ADDR, 32'h200);
        chk("sh_be", 32'(DMEM_BYTE_EN), 32'hC);
        chk("sh_wdata", DMEM_WDATA, 32'hABCDABCD);
        DMEM_ACK = 1'b1;
        tick();
        chk("sh_done_write", 32'(DMEM_WRITE), 32'd0);
        chk("sh_done_novalid", 32'(LOAD_VALID), 32'd0);
        quiet(); tick();

        // SB 0x001 with MEM_READ also high: write wins
        drive(1'b1, 1'b1, 3'b000, 32'h001, 32'h000000A5);
        tick();
        chk("sb_prio_write", 32'(DMEM_WRITE), 32'd1);
        chk("sb_prio_noread", 32'(DMEM_READ), 32'd0);
        chk("sb_be", 32'(DMEM_BYTE_EN), 32'h2);
        chk("sb_wdata", DMEM_WDATA, 32'hA5A5A5A5);
        DMEM_ACK = 1'b1;
        tick();
        quiet(); tick();

        // LW 0x300, no ack: timeout after 4 REQ cycles
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        tick(); tick(); tick(); tick();
        chk("to_req4_strobe", 32'(DMEM_READ), 32'd1);
        chk("to_req4_busy", 32'(BUSYWAIT), 32'd1);
        tick();
        chk("to_done_strobe", 32'(DMEM_READ), 32'd0);
        chk("to_done_berr", 32'(BUS_ERROR), 32'd1);
        chk("to_done_novalid", 32'(LOAD_VALID), 32'd0);
        chk("to_done_busy", 32'(BUSYWAIT), 32'd0);
        quiet(); tick();
        chk("to_berr_pulse", 32'(BUS_ERROR), 32'd0);

        // Ack in the same cycle as the timeout: ack wins
        DMEM_RDATA = 32'h11223344;
        drive(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
        tick(); tick(); tick(); tick();
        DMEM_ACK = 1'b1;
        tick();
        chk("race_valid", 32'(LOAD_VALID), 32'd1);
        chk("race_noberr", 32'(BUS_ERROR), 32'd0);
        chk("race_data", LOAD_DATA, 32'h11223344);
        quiet(); tick();

        // Reset on the second REQ cycle
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        tick(); tick();
        chk("rst_mid_strobe_pre", 32'(DMEM_READ), 32'd1);
        RESET = 1'b1;
        #1;
        chk("rst_mid_strobe", 32'(DMEM_READ), 32'd0);
        chk("rst_mid_addr", DMEM_ADDR, 32'h0);
        chk("rst_mid_busy", 32'(BUSYWAIT), 32'd0);
        quiet();
        tick();
        RESET = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(LOAD_VALID) + int'(BUS_ERROR) + int'(MISALIGNED) + int'(DMEM_READ);
        end
        chk("rst_no_pulses", 32'(pulses), 32'd0);
        drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
        chk("rst_idle_busy", 32'(BUSYWAIT), 32'd1);
        chk("rst_idle_nostrobe", 32'(DMEM_READ), 32'd0);
        quiet();
        #1;

        // LW 0x101: trapped or issued word-aligned depending on build
        DMEM_RDATA = 32'hCAFEF00D;
        drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        chk("mis_idle_busy", 32'(BUSYWAIT), 32'd1);
        tick();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        chk("mis_pulse", 32'(MISALIGNED), 32'd1);
        chk("mis_nostrobe", 32'(DMEM_READ), 32'd0);
        chk("mis_busy_low", 32'(BUSYWAIT), 32'd0);
        quiet(); tick();
        chk("mis_pulse_end", 32'(MISALIGNED), 32'd0);
`else
        chk("mis_tied_low", 32'(MISALIGNED), 32'd0);
        chk("mis_trunc_addr", DMEM_ADDR, 32'h100);
        chk("mis_be", 32'(DMEM_BYTE_EN), 32'hF);
        DMEM_ACK = 1'b1;
        tick();
        chk("mis_word_data", LOAD_DATA, 32'hCAFEF00D);
        quiet(); tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
